gyro_angle_integrator: RTL and testbench
========================================

Name: gyro_angle_integrator

Overview:
Parametrised multi-channel gyro integrator. It calibrates per-channel rate offsets by averaging 2^CAL_LOG2 samples, then integrates offset-compensated rates into angles. An optional per-channel complementary "leak" toward an externally supplied reference angle (accel-derived) is applied each sample. It sits between the inertial sensor interface and the flight controller, and supersedes the fixed 3-axis integrator.

Parameters:
NUM_CH, 3, number of gyro channels (1..8)
CAL_LOG2, 11, log2 of calibration sample count (3 for fast sim)
INT_W, 27, integrator width in bits; INT_W-OUT_SHIFT <= 16 required
OUT_SHIFT, 13, integrator-to-angle right shift
FUSE_STEP, 2048, magnitude added/subtracted per sample by fusion

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
strt_cal  in  1  start/restart calibration pulse
vld  in  1  one-cycle strobe, new rate/ref data valid
rate  in  16*NUM_CH  packed signed raw rates; ch i = [16i+15:16i]
ref_ang  in  16*NUM_CH  packed signed reference angles
fuse_mask  in  NUM_CH  per-channel fusion enable
cal_done  out  1  one-cycle pulse when offsets captured
running  out  1  high in RUN state
ang  out  16*NUM_CH  packed signed angles
ang_vld  out  1  pulses when ang updated
sat_flag  out  NUM_CH  sticky saturation indicator

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. Reset clears all integrators, offsets, sat_flag, the counter and pipeline valids. Outputs ang=0, cal_done=0, running=0, ang_vld=0. State goes to IDLE.
- States are IDLE, CAL and RUN.
  - IDLE to CAL on strt_cal.
  - CAL to RUN when sample count reaches 2^CAL_LOG2.
  - RUN to CAL on strt_cal.
  - strt_cal in CAL restarts calibration.
- Entering or restarting CAL clears the integrators and the sample counter, and squashes both pipeline valid stages, so in-flight samples are dropped.
- Pipeline is two stages.
  - Stage 1, on vld: comp_i = rate_i - off_i (17-bit signed; off_i = 0 outside RUN), and fuse term f_i. Both registered.
  - Stage 2, on vld_d1: int_i <= int_i + sext(comp_i) + f_i. ang_vld asserts the cycle after stage 2, i.e. 2 cycles after vld.
- Sample counter (CAL_LOG2+1 bits) increments on each stage-2 accumulate in CAL. When it equals 2^CAL_LOG2:
  - off_i <= int_i >>> CAL_LOG2, truncated to 16 bits;
  - integrators cleared;
  - cal_done pulses for that single cycle;
  - state moves to RUN.
- Fusion is active only in RUN with fuse_mask[i]=1. Comparison is against the current ang_i:
  - ref_ang_i > ang_i gives f_i = +FUSE_STEP;
  - ref_ang_i < ang_i gives -FUSE_STEP;
  - equal gives 0;
  - otherwise f_i = 0.
- ang_i = int_i[INT_W-1:OUT_SHIFT], sign-extended to 16 bits.
- vld arriving every cycle is legal with a full-throughput pipeline. vld coincident with strt_cal is discarded.
- Without saturation, integrators wrap two's-complement.

Optional Feature:
ANGLE_SAT_EN.
- Defined: stage 2 clamps int_i to [-2^(INT_W-1), 2^(INT_W-1)-1]. Any clamp sets sat_flag[i]. sat_flag is cleared only by reset or by entering CAL.
- Undefined: wrap-around arithmetic; sat_flag tied to 0.

Decomposition:
- Package gyro_integ_pkg holds:
  - the state enum type (IDLE, CAL, RUN);
  - the RATE_W=16 and ANG_W=16 localparams;
  - the function extracting channel i from a packed bus.
- Sub-module gyro_integ_chan holds the per-channel stage-1/stage-2 datapath, offset register, fusion compare and saturation. It is instantiated NUM_CH times in a generate loop. The FSM, counter and valid pipeline stay in the top.

Test Plan:
- Offset calibration (CAL_LOG2=3): rates {100,-40,8} held for 8 vld -> cal_done pulse after the 8th accumulate, off={100,-40,8}. Continued identical rates in RUN with fuse_mask=0 -> ang stays {0,0,0}.
- Rate integration: ch0 offset 0, rate 8192, 4 vld in RUN -> ang0 steps 1,2,3,4; ang_vld exactly 2 cycles after each vld.
- Fusion: rate 0, ref_ang0=5, fuse_mask=1 -> int0 +2048 per sample, ang0=1 after 4 samples. ref_ang0=ang0 -> integrator unchanged.
- Restart: strt_cal after 5 CAL samples, including one sample in flight -> counter cleared, cal_done only after 8 further samples.
- Saturation: rate 32767 in RUN for 2100 samples -> with ANGLE_SAT_EN, int0=2^26-1, ang0=16'h1FFF, sat_flag[0]=1. Without it, ang0 wraps negative and sat_flag=0.
- Reset mid-RUN: deassert rst_n asynchronously -> ang=0, running=0, offsets 0. A later strt_cal recalibrates normally.

Source files
------------

// File: rtl/gyro_integ_pkg.sv
// Shared types and helpers for the multi-channel gyro angle integrator.
package gyro_integ_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, CAL = 2'd1, RUN = 2'd2} state_t;

   localparam int RATE_W = 16;
   localparam int ANG_W  = 16;
   localparam int MAX_CH = 8;
   localparam int BUS_W  = MAX_CH * RATE_W;

   // Callers widen their packed bus to BUS_W so one helper serves any NUM_CH.
   function automatic logic [RATE_W-1:0] get_ch(input logic [BUS_W-1:0] bus, input int i);
      return bus[RATE_W*i +: RATE_W];
   endfunction

endpackage

// File: rtl/gyro_integ_chan.sv
// One gyro channel: offset compensation, fusion term, accumulator, angle output.
// ANGLE_SAT_EN selects a clamping accumulator with a sticky saturation flag.
module gyro_integ_chan
   import gyro_integ_pkg::*;
#(
   parameter int CAL_LOG2  = 11,
   parameter int INT_W     = 27,
   parameter int OUT_SHIFT = 13,
   parameter int FUSE_STEP = 2048
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              s1_en,
   input  logic              s2_en,
   input  logic              in_run,
   input  logic              cap_off,
   input  logic              fuse_en,
   input  logic [RATE_W-1:0] rate,
   input  logic [ANG_W-1:0]  ref_ang,
   output logic [ANG_W-1:0]  ang,
   output logic              sat
);

   localparam logic signed [INT_W-1:0] STEP = INT_W'(FUSE_STEP);

   logic signed [RATE_W:0]   comp, comp_nxt;
   logic signed [INT_W-1:0]  f_term, f_nxt;
   logic signed [INT_W-1:0]  integ, int_nxt;
   logic signed [RATE_W-1:0] off, off_eff;
   logic signed [ANG_W-1:0]  ang_s;

   // Top bits of the accumulator are already sign copies, so truncation sign-extends.
   assign ang_s = ANG_W'(integ >>> OUT_SHIFT);
   assign ang   = ang_s;

   always_comb begin
      off_eff  = in_run ? off : '0;
      comp_nxt = $signed({rate[RATE_W-1], rate}) - $signed({off_eff[RATE_W-1], off_eff});
      f_nxt    = '0;
      if (in_run && fuse_en) begin
         if ($signed(ref_ang) > ang_s)      f_nxt = STEP;
         else if ($signed(ref_ang) < ang_s) f_nxt = -STEP;
      end
   end

`ifdef ANGLE_SAT_EN
   localparam int SUM_W = INT_W + 2;
   localparam logic signed [SUM_W-1:0] MAXV = SUM_W'({1'b0, {(INT_W-1){1'b1}}});
   localparam logic signed [SUM_W-1:0] MINV = ~MAXV;

   logic signed [SUM_W-1:0] sum;
   logic                    clamp;

   assign sum = SUM_W'(integ) + SUM_W'(comp) + SUM_W'(f_term);

   always_comb begin
      clamp   = 1'b0;
      int_nxt = sum[INT_W-1:0];
      if (sum > MAXV) begin
         clamp   = 1'b1;
         int_nxt = MAXV[INT_W-1:0];
      end else if (sum < MINV) begin
         clamp   = 1'b1;
         int_nxt = MINV[INT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                sat <= 1'b0;
      else if (clr)              sat <= 1'b0;
      else if (s2_en && clamp)   sat <= 1'b1;
   end
`else
   assign int_nxt = integ + INT_W'(comp) + f_term;
   assign sat     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         comp   <= '0;
         f_term <= '0;
         integ  <= '0;
         off    <= '0;
      end else begin
         if (s1_en) begin
            comp   <= comp_nxt;
            f_term <= f_nxt;
         end
         if (clr || cap_off) integ <= '0;
         else if (s2_en)     integ <= int_nxt;
         if (cap_off) off <= RATE_W'(integ >>> CAL_LOG2);
      end
   end

endmodule

// File: rtl/gyro_angle_integrator.sv
// Multi-channel gyro integrator: offset calibration FSM, sample counter, 2-stage valid pipe.
// Define ANGLE_SAT_EN for clamping integrators with sticky sat_flag.
module gyro_angle_integrator
   import gyro_integ_pkg::*;
#(
   parameter int NUM_CH    = 3,
   parameter int CAL_LOG2  = 11,
   parameter int INT_W     = 27,
   parameter int OUT_SHIFT = 13,
   parameter int FUSE_STEP = 2048
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     strt_cal,
   input  logic                     vld,
   input  logic [RATE_W*NUM_CH-1:0] rate,
   input  logic [ANG_W*NUM_CH-1:0]  ref_ang,
   input  logic [NUM_CH-1:0]        fuse_mask,
   output logic                     cal_done,
   output logic                     running,
   output logic [ANG_W*NUM_CH-1:0]  ang,
   output logic                     ang_vld,
   output logic [NUM_CH-1:0]        sat_flag
);

   localparam int STAGES = 2;
   localparam logic [CAL_LOG2:0] CNT_FULL = {1'b1, {CAL_LOG2{1'b0}}};

   state_t              state, state_nxt;
   logic [CAL_LOG2:0]   cnt;
   logic [STAGES:1]     vld_pipe;
   logic                s1_en, s2_en, cap_off;

   // strt_cal always wins: it discards the coincident sample and squashes in-flight ones.
   assign s1_en   = vld && !strt_cal;
   assign s2_en   = vld_pipe[1] && !strt_cal;
   assign ang_vld = vld_pipe[STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (strt_cal) state_nxt = CAL;
      else begin
         case (state)
            CAL:     if (cnt == CNT_FULL) state_nxt = RUN;
            IDLE,
            RUN:     state_nxt = state;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      running  = (state == RUN);
      cal_done = 1'b0;
      cap_off  = 1'b0;
      if (state == CAL && cnt == CNT_FULL && !strt_cal) begin
         cal_done = 1'b1;
         cap_off  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         vld_pipe <= '0;
      end else if (strt_cal) begin
         cnt      <= '0;
         vld_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], vld};
         if (cap_off)                                      cnt <= '0;
         else if (state == CAL && s2_en && cnt != CNT_FULL) cnt <= cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      gyro_integ_chan #(
         .CAL_LOG2  (CAL_LOG2),
         .INT_W     (INT_W),
         .OUT_SHIFT (OUT_SHIFT),
         .FUSE_STEP (FUSE_STEP)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (strt_cal),
         .s1_en   (s1_en),
         .s2_en   (s2_en),
         .in_run  (running),
         .cap_off (cap_off),
         .fuse_en (fuse_mask[i]),
         .rate    (get_ch(BUS_W'(rate), i)),
         .ref_ang (get_ch(BUS_W'(ref_ang), i)),
         .ang     (ang[ANG_W*i +: ANG_W]),
         .sat     (sat_flag[i])
      );
   end

endmodule

// File: tb/tb_gyro_angle_integrator.sv
// Directed bench for gyro_angle_integrator (3 channels, CAL_LOG2=3).
// Saturation expectations follow ANGLE_SAT_EN.
module tb_gyro_angle_integrator;

   logic        clk;
   logic        rst_n;
   logic        strt_cal;
   logic        vld;
   logic [47:0] rate;
   logic [47:0] ref_ang;
   logic [2:0]  fuse_mask;
   logic        cal_done;
   logic        running;
   logic [47:0] ang;
   logic        ang_vld;
   logic [2:0]  sat_flag;

   int checks = 0;
   int errors = 0;

   gyro_angle_integrator #(
      .NUM_CH    (3),
      .CAL_LOG2  (3),
      .INT_W     (27),
      .OUT_SHIFT (13),
      .FUSE_STEP (2048)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_cal  (strt_cal),
      .vld       (vld),
      .rate      (rate),
      .ref_ang   (ref_ang),
      .fuse_mask (fuse_mask),
      .cal_done  (cal_done),
      .running   (running),
      .ang       (ang),
      .ang_vld   (ang_vld),
      .sat_flag  (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input int exp);
      checks++;
      assert (obs === 16'(exp)) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, 16'(exp));
      end
   endtask

   task automatic set_rates(input int r0, input int r1, input int r2);
      rate = {16'(r2), 16'(r1), 16'(r0)};
   endtask

   task automatic chk_ang(input string tag, input int a0, input int a1, input int a2);
      chk({tag, "_ang0"}, ang[15:0],  a0);
      chk({tag, "_ang1"}, ang[31:16], a1);
      chk({tag, "_ang2"}, ang[47:32], a2);
   endtask

   // One vld strobe; ang_vld must appear exactly two cycles later.
   task automatic sample();
      vld = 1'b1;
      step();
      vld = 1'b0;
      chk("ang_vld_early", 16'(ang_vld), 0);
      step();
      chk("ang_vld", 16'(ang_vld), 1);
   endtask

   task automatic pulse_cal();
      strt_cal = 1'b1;
      step();
      strt_cal = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      strt_cal  = 1'b0;
      vld       = 1'b0;
      rate      = '0;
      ref_ang   = '0;
      fuse_mask = '0;

      // Reset state
      #12;
      chk_ang("rst", 0, 0, 0);
      chk("rst_running", 16'(running), 0);
      chk("rst_cal_done", 16'(cal_done), 0);
      chk("rst_ang_vld", 16'(ang_vld), 0);
      chk("rst_sat", 16'(sat_flag), 0);
      #5 rst_n = 1'b1;
      step();

      // Calibration with rates {100,-40,8}
      pulse_cal();
      chk("cal_running", 16'(running), 0);
      set_rates(100, -40, 8);
      for (int k = 0; k < 8; k++) begin
         sample();
         chk("cal_done_k", 16'(cal_done), (k == 7) ? 1 : 0);
      end
      step();
      chk("cal_done_once", 16'(cal_done), 0);
      chk("run_entered", 16'(running), 1);

      // Same rates after calibration cancel out
      for (int k = 0; k < 2; k++) begin
         sample();
         chk_ang("comp_zero", 0, 0, 0);
      end

      // One full LSB of angle per sample after offset removal
      set_rates(100 + 8192, -40 - 8192, 8 + 8192);
      for (int k = 1; k <= 4; k++) begin
         sample();
         chk_ang("integ", k, -k, k);
      end

      // Fusion on ch0 toward ref 5; ch1 has a ref but no mask
      set_rates(100, -40, 8);
      ref_ang   = {16'd0, 16'd100, 16'd5};
      fuse_mask = 3'b001;
      for (int k = 1; k <= 4; k++) begin
         sample();
         chk_ang("fuse_up", (k == 4) ? 5 : 4, -4, 4);
      end
      sample();
      chk("fuse_equal", ang[15:0], 5);
      ref_ang[15:0] = 16'd4;
      sample();
      chk("fuse_down", ang[15:0], 4);
      sample();
      chk("fuse_equal2", ang[15:0], 4);
      chk("fuse_mask_off", ang[31:16], -4);

      // Restart calibration mid-way with a sample in flight
      fuse_mask = 3'b000;
      ref_ang   = '0;
      pulse_cal();
      chk("restart_running", 16'(running), 0);
      chk_ang("restart_clr", 0, 0, 0);
      set_rates(800, 0, 0);
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("restart_pre", 16'(cal_done), 0);
      end
      set_rates(8000, 0, 0);
      vld = 1'b1;
      step();
      vld = 1'b0;
      strt_cal = 1'b1;
      step();
      strt_cal = 1'b0;
      chk("squash_vld", 16'(ang_vld), 0);
      chk("squash_ang", ang[15:0], 0);
      set_rates(0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         sample();
         chk("restart_cal_done", 16'(cal_done), (k == 7) ? 1 : 0);
      end
      step();
      chk("restart_run", 16'(running), 1);
      sample();
      chk_ang("restart_off0", 0, 0, 0);

      // Saturation / wrap with full-throughput vld
      set_rates(32767, 0, 0);
      vld = 1'b1;
      for (int k = 0; k < 2100; k++) step();
      vld = 1'b0;
      step();
      step();
`ifdef ANGLE_SAT_EN
      chk("sat_ang0", ang[15:0], 'h1FFF);
      chk("sat_flag", 16'(sat_flag), 1);
`else
      chk("wrap_ang0", ang[15:0], 'hE0CF);
      chk("wrap_flag", 16'(sat_flag), 0);
`endif
      chk("sat_ang1", ang[31:16], 0);

      // Asynchronous reset mid-RUN
      #3 rst_n = 1'b0;
      #1;
      chk_ang("arst", 0, 0, 0);
      chk("arst_running", 16'(running), 0);
      chk("arst_sat", 16'(sat_flag), 0);
      chk("arst_ang_vld", 16'(ang_vld), 0);
      #2 rst_n = 1'b1;
      step();
      pulse_cal();
      set_rates(50, 0, 0);
      for (int k = 0; k < 8; k++) begin
         sample();
         chk("recal_cal_done", 16'(cal_done), (k == 7) ? 1 : 0);
      end
      step();
      chk("recal_run", 16'(running), 1);
      set_rates(50 + 8192, 0, 0);
      sample();
      chk_ang("recal", 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
